branch_flush_sequencer: RTL and testbench

Sequences pipeline recovery when a control-flow instruction in the ALU stage resolves against its prediction, or is a JALR.
Registers the redirect PC and presents it to fetch with a valid/ready handshake.
Squashes the wrong-path contents of the decoded, reg-access and ALU latches, then masks further detection for a programmable drain window.
Sits beside the pipeline halt control and drives the same per-stage bubble (_x) controls.

---
 rtl/branch_flush_sequencer.sv | 118 +++++++++++
 tb/tb_branch_flush_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_flush_sequencer.sv
// Branch/JALR recovery sequencer: captures the redirect PC, hands it to fetch
// over valid/ready, flushes the wrong-path latches, then masks detection while the pipe drains.
module branch_flush_sequencer #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic             alu_is_branch,
  input  logic             alu_is_jalr,
  input  logic             predicted_taken,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  alu_pc,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  jalr_target,
  input  logic             stall_in,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             decoded_x,
  output logic             reg_access_x,
  output logic             alu_x,
  output logic             fetch_hold,
  output logic             busy,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REDIRECT = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES > 0) ? DRN_W'(DRAIN_CYCLES - 1) : '0;

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0] drain_q, drain_d;

  logic             trigger;
  logic [XLEN-1:0]  target;

  assign trigger = alu_valid & ~stall_in &
                   (alu_is_jalr | (alu_is_branch & (predicted_taken ^ branch_taken)));

  // JALR wins over the branch flags; the not-taken path wraps modulo 2^XLEN.
  always_comb begin
    if (alu_is_jalr)       target = jalr_target & ~XLEN'(1);
    else if (branch_taken) target = branch_target;
    else                   target = alu_pc + XLEN'(4);
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_REDIRECT;
          pc_d    = target;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          pc_d = '0;
          if (DRAIN_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_IDLE;
        else               drain_d = drain_q - DRN_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        drain_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  assign redirect_valid   = (state_q == S_REDIRECT);
  assign decoded_x        = (state_q == S_REDIRECT);
  assign reg_access_x     = (state_q == S_REDIRECT);
  assign alu_x            = (state_q == S_REDIRECT);
  assign fetch_hold       = (state_q == S_REDIRECT);
  assign busy             = (state_q != S_IDLE);
  assign redirect_pc      = pc_q;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_flush_sequencer.sv
// Scoreboard bench: instance A uses default parameters, instance B has no drain
// window and a 2-bit counter to reach back-to-back triggers and saturation cheaply.
module tb_branch_flush_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_is_branch = 1'b0, alu_is_jalr = 1'b0;
  logic        predicted_taken = 1'b0, branch_taken = 1'b0, stall_in = 1'b0;
  logic [31:0] alu_pc = '0, branch_target = '0, jalr_target = '0;
  logic        valid_a = 1'b0, ready_a = 1'b0, valid_b = 1'b0, ready_b = 1'b0;

  logic        rv_a, dx_a, rx_a, ax_a, fh_a, busy_a;
  logic [31:0] pc_a;
  logic [15:0] cnt_a;
  logic        rv_b, dx_b, rx_b, ax_b, fh_b, busy_b;
  logic [31:0] pc_b;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad   = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  always #5 clk = ~clk;

  branch_flush_sequencer u_a (
    .clk(clk), .rst_n(rst_n), .alu_valid(valid_a), .alu_is_branch(alu_is_branch),
    .alu_is_jalr(alu_is_jalr), .predicted_taken(predicted_taken), .branch_taken(branch_taken),
    .alu_pc(alu_pc), .branch_target(branch_target), .jalr_target(jalr_target),
    .stall_in(stall_in), .redirect_ready(ready_a), .redirect_valid(rv_a), .redirect_pc(pc_a),
    .decoded_x(dx_a), .reg_access_x(rx_a), .alu_x(ax_a), .fetch_hold(fh_a), .busy(busy_a),
    .mispredict_count(cnt_a)
  );

  branch_flush_sequencer #(.XLEN(32), .DRAIN_CYCLES(0), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .alu_valid(valid_b), .alu_is_branch(alu_is_branch),
    .alu_is_jalr(alu_is_jalr), .predicted_taken(predicted_taken), .branch_taken(branch_taken),
    .alu_pc(alu_pc), .branch_target(branch_target), .jalr_target(jalr_target),
    .stall_in(stall_in), .redirect_ready(ready_b), .redirect_valid(rv_b), .redirect_pc(pc_b),
    .decoded_x(dx_b), .reg_access_x(rx_b), .alu_x(ax_b), .fetch_hold(fh_b), .busy(busy_b),
    .mispredict_count(cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Packs {redirect_valid, decoded_x, reg_access_x, alu_x, fetch_hold, busy}.
  function automatic logic [5:0] outs_a();
    return {rv_a, dx_a, rx_a, ax_a, fh_a, busy_a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_branch(input logic pt, input logic bt, input logic [31:0] pc,
                            input logic [31:0] tgt);
    alu_is_branch = 1'b1; alu_is_jalr = 1'b0;
    predicted_taken = pt; branch_taken = bt; alu_pc = pc; branch_target = tgt;
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (busy_a && n < 20) begin tick(); n++; end
    check({tag, "_idle"}, {63'd0, busy_a}, 64'd0);
  endtask

  // Each accepted handshake pops the expected PC; an unexpected one is a failure.
  always @(negedge clk) begin
    if (rst_n && rv_a && ready_a) begin
      if (q_a.size() == 0) check("a_unexpected_redirect", {32'd0, pc_a}, 64'hDEAD);
      else                 check("a_redirect_pc", {32'd0, pc_a}, {32'd0, q_a.pop_front()});
    end
    if (rst_n && rv_b && ready_b) begin
      if (q_b.size() == 0) check("b_unexpected_redirect", {32'd0, pc_b}, 64'hDEAD);
      else                 check("b_redirect_pc", {32'd0, pc_b}, {32'd0, q_b.pop_front()});
    end
  end

  initial begin
    #12;
    check("rst_outs_a", outs_a(), 6'b0);
    check("rst_pc_a", pc_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_outs_b", {rv_b, dx_b, rx_b, ax_b, fh_b, busy_b}, 6'b0);
    rst_n = 1'b1;
    tick();

    // 1: not-taken prediction resolves taken, fetch ready at once.
    set_branch(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0100);
    valid_a = 1'b1; ready_a = 1'b1; q_a.push_back(32'h0000_0100);
    tick();
    valid_a = 1'b0;
    check("t1_redirect_outs", outs_a(), 6'b111111);
    check("t1_pc", pc_a, 32'h100);
    check("t1_cnt", cnt_a, 1);
    tick();
    check("t1_drain1_outs", outs_a(), 6'b000001);
    tick();
    check("t1_drain2_outs", outs_a(), 6'b000001);
    tick();
    check("t1_idle_outs", outs_a(), 6'b000000);

    // 2: taken prediction resolves not-taken at the top of the address space.
    set_branch(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678);
    valid_a = 1'b1; q_a.push_back(32'h0000_0000);
    tick();
    valid_a = 1'b0;
    check("t2_valid", rv_a, 1);
    check("t2_pc_wrap", pc_a, 0);
    check("t2_cnt", cnt_a, 2);
    wait_idle_a("t2");

    // 3: JALR with the branch flag also set; fetch stalls the handshake three cycles.
    set_branch(1'b0, 1'b0, 32'h0000_0800, 32'h0000_0900);
    alu_is_jalr = 1'b1; jalr_target = 32'h0000_2003;
    valid_a = 1'b1; ready_a = 1'b0; q_a.push_back(32'h0000_2002);
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_hold%0d_outs", i), outs_a(), 6'b111111);
      check($sformatf("t3_hold%0d_pc", i), pc_a, 32'h2002);
      if (i == 3) ready_a = 1'b1;
      tick();
    end
    check("t3_released", rv_a, 0);
    check("t3_cnt", cnt_a, 3);
    wait_idle_a("t3");
    alu_is_jalr = 1'b0;

    // 4: a correct prediction does nothing; a stalled mispredict fires once after the stall.
    set_branch(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0380);
    valid_a = 1'b1;
    tick(); tick();
    check("t4_correct_outs", outs_a(), 6'b000000);
    check("t4_correct_cnt", cnt_a, 3);
    set_branch(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0400);
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("t4_stall%0d_valid", i), rv_a, 0);
    end
    stall_in = 1'b0; q_a.push_back(32'h0000_0400);
    tick();
    valid_a = 1'b0;
    check("t4_fire_valid", rv_a, 1);
    wait_idle_a("t4");
    check("t4_cnt", cnt_a, 4);

    // 5: a second mispredict held through REDIRECT and DRAIN is dropped.
    set_branch(1'b0, 1'b1, 32'h0000_0480, 32'h0000_0500);
    valid_a = 1'b1; q_a.push_back(32'h0000_0500);
    tick();
    branch_target = 32'h0000_0600;
    tick();
    check("t5_drain_valid_a", rv_a, 0);
    tick();
    check("t5_drain_busy", busy_a, 1);
    tick();
    valid_a = 1'b0;
    check("t5_back_idle", outs_a(), 6'b000000);
    tick();
    check("t5_cnt", cnt_a, 5);

    // 5b: no drain window, so a held trigger re-fires right after acceptance.
    set_branch(1'b0, 1'b1, 32'h0000_0680, 32'h0000_0700);
    valid_b = 1'b1; ready_b = 1'b1; q_b.push_back(32'h0000_0700);
    tick();
    check("t5b_first_valid", rv_b, 1);
    branch_target = 32'h0000_0800; q_b.push_back(32'h0000_0800);
    tick();
    check("t5b_accept_idle", busy_b, 0);
    tick();
    valid_b = 1'b0;
    check("t5b_second_valid", rv_b, 1);
    check("t5b_second_pc", pc_b, 32'h800);
    check("t5b_cnt", cnt_b, 2);
    tick();

    // 6b: the 2-bit counter saturates at all-ones.
    for (int i = 0; i < 2; i++) begin
      branch_target = 32'h0000_0900 + 32'(i * 4);
      q_b.push_back(32'h0000_0900 + 32'(i * 4));
      valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      tick();
    end
    check("t6_cnt_saturated", cnt_b, 3);

    // 6: asynchronous reset in the middle of REDIRECT.
    set_branch(1'b0, 1'b1, 32'h0000_0a00, 32'h0000_0b00);
    valid_a = 1'b1; ready_a = 1'b0;
    tick();
    valid_a = 1'b0;
    check("t6_in_redirect", rv_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_outs", outs_a(), 6'b000000);
    check("t6_rst_pc", pc_a, 0);
    check("t6_rst_cnt", cnt_a, 0);
    #2 rst_n = 1'b1;
    ready_a = 1'b1;
    tick(); tick();
    check("t6_after_rst_outs", outs_a(), 6'b000000);
    check("t6_after_rst_cnt", cnt_a, 0);

    check("sb_a_empty", q_a.size(), 0);
    check("sb_b_empty", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
